// File: rtl/gift_inv_sbox_masked_serial.sv
// Three-share masked inverse GIFT S-box layer, one nibble per cycle through a two-stage (G then F) quadratic core.
// Latency NIBBLES+2 edges from accept to out_valid; in_ready only in IDLE, result held in DONE until out_ready.
module gift_inv_sbox_masked_serial #(
    parameter int NIBBLES = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] in_s1,
    input  logic [4*NIBBLES-1:0] in_s2,
    input  logic [4*NIBBLES-1:0] in_s3,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] out_s1,
    output logic [4*NIBBLES-1:0] out_s2,
    output logic [4*NIBBLES-1:0] out_s3,
    output logic                 busy
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);
    localparam int FW = $clog2(NIBBLES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [W-1:0]         s1_q, s1_d;
    logic [W-1:0]         s2_q, s2_d;
    logic [W-1:0]         s3_q, s3_d;
    logic [FW-1:0]        f_q, f_d;
    logic [IW-1:0]        w_q, w_d;
    logic [1:0]           v_q, v_d;
    logic [2:0][2:0][4:0] gc_q, gc_d;
    logic [2:0][2:0][3:0] fc_q, fc_d;

    logic [IW-1:0]        rd_idx;
    logic [2:0][3:0]      x_sh;
    logic [2:0][4:0]      g_sh;
    logic [2:0][3:0]      r_sh;
    logic                 feed;

    // G lifts the nibble to 5 bits {x0&x1, x3..x0}; the only cubic terms of InvS
    // (x0x1x3, x0x1x2) then become quadratic in F. Component (i,j) sees shares i and j only.
    function automatic logic [4:0] g_comp(input logic [3:0] xi, input logic [3:0] xj,
                                          input logic diag);
        g_comp = {xi[0] & xj[1], (diag ? xi : 4'h0)};
    endfunction

    function automatic logic [3:0] f_comp(input logic [4:0] gi, input logic [4:0] gj,
                                          input logic diag, input logic cnst);
        logic [3:0] q;
        logic [3:0] l;
        q[0] = (gi[0] & gj[2]) ^ (gi[1] & gj[2]) ^ (gi[4] & gj[3]);
        q[1] = (gi[0] & gj[2]) ^ (gi[1] & gj[2]) ^ (gi[4] & gj[2])
             ^ (gi[1] & gj[3]) ^ (gi[2] & gj[3]);
        q[2] = gi[0] & gj[3];
        q[3] = gi[1] & gj[3];
        l[0] = gi[0] ^ gi[1] ^ gi[2] ^ gi[3] ^ gi[4];
        l[1] = gi[2] ^ gi[3] ^ gi[4];
        l[2] = gi[0] ^ gi[1] ^ gi[2];
        l[3] = gi[0] ^ gi[2];
        f_comp = q ^ (diag ? l : 4'h0) ^ (cnst ? 4'hd : 4'h0);
    endfunction

    always_comb begin
        feed   = (state_q == RUN) && (f_q < FW'(NIBBLES));
        rd_idx = feed ? f_q[IW-1:0] : '0;
        x_sh[0] = s1_q[{rd_idx, 2'b00} +: 4];
        x_sh[1] = s2_q[{rd_idx, 2'b00} +: 4];
        x_sh[2] = s3_q[{rd_idx, 2'b00} +: 4];
    end

    // Compression directly after each register bank is the only place share terms meet.
    always_comb begin
        gc_d = '0;
        fc_d = '0;
        g_sh = '0;
        r_sh = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                gc_d[i][j] = g_comp(x_sh[i], x_sh[j], (i == j));
            end
            g_sh[i] = gc_q[i][0] ^ gc_q[i][1] ^ gc_q[i][2];
        end
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                fc_d[i][j] = f_comp(g_sh[i], g_sh[j], (i == j), (i == 0) && (j == 0));
            end
            r_sh[i] = fc_q[i][0] ^ fc_q[i][1] ^ fc_q[i][2];
        end
    end

    always_comb begin
        state_d = state_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        s3_d    = s3_q;
        f_d     = f_q;
        w_d     = w_q;
        v_d     = v_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    s1_d    = in_s1;
                    s2_d    = in_s2;
                    s3_d    = in_s3;
                    f_d     = '0;
                    w_d     = '0;
                    v_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (feed) begin
                    f_d = f_q + FW'(1);
                end
                v_d = {v_q[0], feed};
                // Write-back trails the read pointer by two nibbles, so it never aliases it.
                if (v_q[1]) begin
                    s1_d[{w_q, 2'b00} +: 4] = r_sh[0];
                    s2_d[{w_q, 2'b00} +: 4] = r_sh[1];
                    s3_d[{w_q, 2'b00} +: 4] = r_sh[2];
                    w_d = w_q + IW'(1);
                    if (w_q == IW'(NIBBLES - 1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            s1_q    <= '0;
            s2_q    <= '0;
            s3_q    <= '0;
            f_q     <= '0;
            w_q     <= '0;
            v_q     <= '0;
            gc_q    <= '0;
            fc_q    <= '0;
        end else begin
            state_q <= state_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            s3_q    <= s3_d;
            f_q     <= f_d;
            w_q     <= w_d;
            v_q     <= v_d;
            gc_q    <= gc_d;
            fc_q    <= fc_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN);
    assign out_s1    = s1_q;
    assign out_s2    = s2_q;
    assign out_s3    = s3_q;

endmodule

// File: tb/tb_gift_inv_sbox_masked_serial.sv
// Scoreboarded bench: directed and random masked states into 16- and 32-nibble instances.
module tb_gift_inv_sbox_masked_serial;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic        iv_a, ir_a, ov_a, ordy_a, busy_a;
    logic [63:0] is1_a, is2_a, is3_a, os1_a, os2_a, os3_a;
    logic         iv_b, ir_b, ov_b, ordy_b, busy_b;
    logic [127:0] is1_b, is2_b, is3_b, os1_b, os2_b, os3_b;

    gift_inv_sbox_masked_serial #(.NIBBLES(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_a), .in_ready(ir_a),
        .in_s1(is1_a), .in_s2(is2_a), .in_s3(is3_a),
        .out_valid(ov_a), .out_ready(ordy_a),
        .out_s1(os1_a), .out_s2(os2_a), .out_s3(os3_a), .busy(busy_a));

    gift_inv_sbox_masked_serial #(.NIBBLES(32)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_b), .in_ready(ir_b),
        .in_s1(is1_b), .in_s2(is2_b), .in_s3(is3_b),
        .out_valid(ov_b), .out_ready(ordy_b),
        .out_s1(os1_b), .out_s2(os2_b), .out_s3(os3_b), .busy(busy_b));

    typedef struct {
        logic [127:0] exp;
        int           acc;
    } exp_t;
    exp_t q_a[$];
    exp_t q_b[$];

    function automatic logic [3:0] invs4(input logic [3:0] v);
        case (v)
            4'h0: return 4'hd;  4'h1: return 4'h0;  4'h2: return 4'h8;  4'h3: return 4'h6;
            4'h4: return 4'h2;  4'h5: return 4'hc;  4'h6: return 4'h4;  4'h7: return 4'hb;
            4'h8: return 4'he;  4'h9: return 4'h7;  4'ha: return 4'h1;  4'hb: return 4'ha;
            4'hc: return 4'h3;  4'hd: return 4'h9;  4'he: return 4'hf;  default: return 4'h5;
        endcase
    endfunction

    function automatic logic [127:0] invs_state(input logic [127:0] x, input int n);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < n; k++) r[4*k +: 4] = invs4(x[4*k +: 4]);
        return r;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    exp_t        e_a, e_b;
    bit          seen_a = 1'b0, seen_b = 1'b0;
    logic [63:0] last_s1_a;

    always @(negedge clk) begin
        if (!ov_a) seen_a = 1'b0;
        else if (!seen_a) begin
            seen_a = 1'b1;
            if (q_a.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_out_a: out_valid with no pending state at cycle %0d", cyc);
            end else begin
                e_a = q_a.pop_front();
                check("xor_a", {192'h0, os1_a ^ os2_a ^ os3_a}, e_a.exp);
                check("latency_a", cyc - e_a.acc, 18);
                last_s1_a = os1_a;
            end
        end
    end

    always @(negedge clk) begin
        if (!ov_b) seen_b = 1'b0;
        else if (!seen_b) begin
            seen_b = 1'b1;
            if (q_b.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_out_b: out_valid with no pending state at cycle %0d", cyc);
            end else begin
                e_b = q_b.pop_front();
                check("xor_b", {128'h0, os1_b ^ os2_b ^ os3_b}, e_b.exp);
                check("latency_b", cyc - e_b.acc, 34);
            end
        end
    end

    task automatic send(input bit b, input logic [127:0] x, input logic [127:0] exp, input bit poke);
        logic [127:0] m2, m3, s1;
        exp_t         ent;
        int           t;
        m2 = {$urandom(), $urandom(), $urandom(), $urandom()};
        m3 = {$urandom(), $urandom(), $urandom(), $urandom()};
        s1 = x ^ m2 ^ m3;
        t  = 0;
        @(negedge clk);
        while (!(b ? ir_b : ir_a) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!(b ? ir_b : ir_a)) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready=0 after %0d cycles, required 1", t);
            return;
        end
        if (b) begin
            iv_b = 1'b1; is1_b = s1; is2_b = m2; is3_b = m3;
        end else begin
            iv_a = 1'b1; is1_a = s1[63:0]; is2_a = m2[63:0]; is3_a = m3[63:0];
        end
        @(posedge clk);
        #1;
        ent.exp = exp;
        ent.acc = cyc;
        if (b) begin
            iv_b = 1'b0; q_b.push_back(ent);
        end else begin
            iv_a = 1'b0; q_a.push_back(ent);
        end
        if (poke) begin
            repeat (4) begin
                @(negedge clk);
                iv_a = 1'b1;
                is1_a = {$urandom(), $urandom()};
                is2_a = {$urandom(), $urandom()};
                is3_a = {$urandom(), $urandom()};
            end
            @(negedge clk);
            iv_a = 1'b0;
        end
    endtask

    task automatic wait_done(input bit b);
        int t;
        t = 0;
        while ((b ? q_b.size() : q_a.size()) != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if ((b ? q_b.size() : q_a.size()) != 0) begin
            checks++; errors++;
            $display("FAIL done_timeout: no out_valid within %0d cycles (dut %0d)", t, b);
            if (b) q_b.delete(); else q_a.delete();
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [191:0] snap;
    logic [63:0]  first_s1;
    logic [63:0]  rx;
    logic [127:0] rxb;
    int           vary;

    initial begin
        rst_n = 1'b0;
        iv_a = 1'b0; ordy_a = 1'b1; is1_a = '0; is2_a = '0; is3_a = '0;
        iv_b = 1'b0; ordy_b = 1'b1; is1_b = '0; is2_b = '0; is3_b = '0;
        #1;
        check("in_reset_a", {ir_a, ov_a, busy_a}, 3'b100);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ctrl_a", {ir_a, ov_a, busy_a}, 3'b100);
        check("rst_shares_a", os1_a | os2_a | os3_a, 0);
        check("rst_ctrl_b", {ir_b, ov_b, busy_b}, 3'b100);
        check("rst_shares_b", os1_b | os2_b | os3_b, 0);

        send(0, 64'h0123456789abcdef, 64'hd0862c4be71a39f5, 0); wait_done(0);
        send(0, 64'h1a4c6f392db7508e, 64'h0123456789abcdef, 0); wait_done(0);
        send(0, 64'hfedcba9876543210, 64'h5f93a17eb4c2680d, 0); wait_done(0);
        send(0, 64'hffffffffffffffff, 64'h5555555555555555, 0); wait_done(0);

        for (int i = 0; i < 200; i++) begin
            rx = {$urandom(), $urandom()};
            send(0, {64'h0, rx}, invs_state({64'h0, rx}, 16), 0);
            wait_done(0);
        end

        vary = 0;
        for (int i = 0; i < 100; i++) begin
            send(0, 128'h0, 64'hdddddddddddddddd, 0);
            wait_done(0);
            if (i == 0) first_s1 = last_s1_a;
            else if (last_s1_a != first_s1) vary++;
        end
        checks++;
        if (vary == 0) begin
            errors++;
            $display("FAIL share_variation: out_s1 identical across %0d masked runs, required variation", 100);
        end

        ordy_a = 1'b0;
        send(0, 64'h0123456789abcdef, 64'hd0862c4be71a39f5, 1);
        wait_done(0);
        snap = {os1_a, os2_a, os3_a};
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("stall_hold", {ov_a, ir_a, busy_a, os1_a, os2_a, os3_a}, {3'b100, snap});
            iv_a = (i % 3 == 0);
        end
        @(negedge clk);
        iv_a = 1'b0;
        ordy_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("release", {ir_a, ov_a}, 2'b10);

        send(0, 64'h0123456789abcdef, 64'hd0862c4be71a39f5, 0);
        repeat (7) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_ctrl", {ir_a, ov_a, busy_a}, 3'b100);
        check("midrst_shares", os1_a | os2_a | os3_a, 0);
        q_a.delete();
        @(negedge clk);
        rst_n = 1'b1;
        send(0, 64'h1a4c6f392db7508e, 64'h0123456789abcdef, 0); wait_done(0);

        send(1, {2{64'h0123456789abcdef}}, {2{64'hd0862c4be71a39f5}}, 0); wait_done(1);
        send(1, {2{64'h1a4c6f392db7508e}}, {2{64'h0123456789abcdef}}, 0); wait_done(1);
        for (int i = 0; i < 10; i++) begin
            rxb = {$urandom(), $urandom(), $urandom(), $urandom()};
            send(1, rxb, invs_state(rxb, 32), 0);
            wait_done(1);
        end

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
